// File: rtl/seq_mult_ctrl_if.sv
// ----------------------------------------------------------------------------
// seq_mult_ctrl_if
// Handshake and result bundle for the sequential shift-add multiplier.
//
// Parameter:
//   WIDTH   operand width in bits; the product is 2*WIDTH bits
//
// Signals:
//   start    requester -> multiplier  begin a multiply (sampled when ready=1)
//   a        requester -> multiplier  multiplicand, captured on accept
//   b        requester -> multiplier  multiplier, captured on accept
//   ready    multiplier -> requester  high while the multiplier is idle
//   done     multiplier -> requester  one-cycle strobe, product is valid
//   product  multiplier -> requester  result register, held until next result
//
// Modports:
//   master  the requester side (drives start/a/b)
//   slave   the multiplier side (drives ready/done/product)
// ----------------------------------------------------------------------------
interface seq_mult_ctrl_if #(
   parameter int WIDTH = 4
);
   logic                   start;
   logic [WIDTH-1:0]       a;
   logic [WIDTH-1:0]       b;
   logic                   ready;
   logic                   done;
   logic [2*WIDTH-1:0]     product;

   modport master (
      output start,
      output a,
      output b,
      input  ready,
      input  done,
      input  product
   );

   modport slave (
      input  start,
      input  a,
      input  b,
      output ready,
      output done,
      output product
   );
endinterface

// File: rtl/seq_mult_ctrl.sv
// ----------------------------------------------------------------------------
// seq_mult_ctrl
// Sequential shift-add unsigned multiplier. Operands are accepted on a
// start/ready handshake, one partial-product step is taken per clock for
// WIDTH clocks, then the 2*WIDTH-bit product is loaded into the result
// register together with a one-cycle done strobe.
//
// Parameter:
//   WIDTH   operand width in bits (2..16); product is 2*WIDTH bits
//
// Ports:
//   clk     rising-edge clock
//   rst     asynchronous, active-high reset (aborts any multiply in flight)
//   bus     seq_mult_ctrl_if slave modport: start, a, b in; ready, done,
//           product out
//
// Build option:
//   SEQ_MULT_ZERO_SKIP_EN  when defined, an accept with a zero operand goes
//                          straight to DONE with a zero product instead of
//                          running the full WIDTH-step loop.
// ----------------------------------------------------------------------------
module seq_mult_ctrl #(
   parameter int WIDTH = 4
) (
   input  logic            clk,
   input  logic            rst,
   seq_mult_ctrl_if.slave  bus
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   state_t                 state;
   logic [WIDTH-1:0]       a_reg;
   logic [2*WIDTH-1:0]     p_reg;
   logic [2*WIDTH-1:0]     p_next;
   logic [WIDTH:0]         sum;
   logic [CW-1:0]          cnt;
   logic                   done_reg;
   logic [2*WIDTH-1:0]     product_reg;
   logic                   zero_skip;

   // One shift-add step: the upper half of P plus the multiplicand (when the
   // current multiplier bit, P[0], is set) gives a WIDTH+1-bit sum whose
   // carry lands in the top bit. The whole P then shifts right by one, so the
   // consumed multiplier bit drops off the bottom.
   always_comb begin
      sum    = {1'b0, p_reg[2*WIDTH-1:WIDTH]} + (p_reg[0] ? {1'b0, a_reg} : '0);
      p_next = {sum, p_reg[WIDTH-1:1]};
   end

   // A zero operand can only ever produce a zero product, so with the
   // shortcut built in the controller may skip the whole stepping loop.
`ifdef SEQ_MULT_ZERO_SKIP_EN
   assign zero_skip = (bus.a == '0) || (bus.b == '0);
`else
   assign zero_skip = 1'b0;
`endif

   // Ready is simply "we are idle"; it is decoded from the state so that it
   // drops right after the accept edge and rises right after DONE.
   assign bus.ready   = (state == IDLE);
   assign bus.done    = done_reg;
   assign bus.product = product_reg;

   // Controller and datapath registers. IDLE loads the operands on accept,
   // CALC performs exactly WIDTH steps and captures the final P into the
   // result register on the last one, DONE holds the strobe for one cycle.
   // The result register is only written on a done edge (or cleared by
   // reset), so it holds steady through IDLE and the next calculation.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         a_reg       <= '0;
         p_reg       <= '0;
         cnt         <= '0;
         done_reg    <= 1'b0;
         product_reg <= '0;
      end else begin
         case (state)
            IDLE: begin
               done_reg <= 1'b0;
               if (bus.start) begin
                  a_reg <= bus.a;
                  p_reg <= {{WIDTH{1'b0}}, bus.b};
                  cnt   <= '0;
                  if (zero_skip) begin
                     product_reg <= '0;
                     done_reg    <= 1'b1;
                     state       <= DONE;
                  end else begin
                     state <= CALC;
                  end
               end
            end
            CALC: begin
               p_reg <= p_next;
               cnt   <= cnt + CW'(1);
               if (cnt == LAST_STEP) begin
                  product_reg <= p_next;
                  done_reg    <= 1'b1;
                  state       <= DONE;
               end
            end
            DONE: begin
               done_reg <= 1'b0;
               state    <= IDLE;
            end
            default: begin
               done_reg <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// ----------------------------------------------------------------------------
// tb_seq_mult_ctrl
// Self-checking bench for seq_mult_ctrl. A WIDTH=4 instance is compared every
// cycle against a latency/arithmetic model; a WIDTH=8 instance covers the
// wide maximum-value case with directed checks.
// ----------------------------------------------------------------------------
module tb_seq_mult_ctrl;

   localparam int W  = 4;
   localparam int W8 = 8;

`ifdef SEQ_MULT_ZERO_SKIP_EN
   localparam int ZERO_LAT = 0;
`else
   localparam int ZERO_LAT = W;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;

   always #5 clk = ~clk;

   seq_mult_ctrl_if #(.WIDTH(W))  bus4 ();
   seq_mult_ctrl_if #(.WIDTH(W8)) bus8 ();

   seq_mult_ctrl #(.WIDTH(W)) dut4 (
      .clk (clk),
      .rst (rst),
      .bus (bus4)
   );

   seq_mult_ctrl #(.WIDTH(W8)) dut8 (
      .clk (clk),
      .rst (rst),
      .bus (bus8)
   );

   int errors = 0;
   int checks = 0;

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Behavioural model: an accepted multiply yields a*b after W edges (or
   // immediately when the zero shortcut applies), done lasts one cycle, and
   // ready is high whenever no multiply is pending or being reported.
   logic             m_done;
   logic [2*W-1:0]   m_product;
   logic [2*W-1:0]   m_res;
   int               m_left;
   logic             m_ready;

   assign m_ready = !m_done && (m_left == 0);

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_done    <= 1'b0;
         m_product <= '0;
         m_res     <= '0;
         m_left    <= 0;
      end else if (m_done) begin
         m_done <= 1'b0;
      end else if (m_left != 0) begin
         m_left <= m_left - 1;
         if (m_left == 1) begin
            m_done    <= 1'b1;
            m_product <= m_res;
         end
      end else if (bus4.start) begin
         m_res <= (2*W)'(bus4.a) * (2*W)'(bus4.b);
`ifdef SEQ_MULT_ZERO_SKIP_EN
         if (bus4.a == 0 || bus4.b == 0) begin
            m_done    <= 1'b1;
            m_product <= '0;
         end else begin
            m_left <= W;
         end
`else
         m_left <= W;
`endif
      end
   end

   // Compare the WIDTH=4 outputs against the model on every falling edge.
   always @(negedge clk) begin
      checkOutput("cyc_ready",   64'(bus4.ready),   64'(m_ready));
      checkOutput("cyc_done",    64'(bus4.done),    64'(m_done));
      checkOutput("cyc_product", 64'(bus4.product), 64'(m_product));
   end

   task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      bus4.a     = a;
      bus4.b     = b;
      bus4.start = 1'b1;
      @(negedge clk);
      bus4.start = 1'b0;
   endtask

   task automatic waitDone(input string name, inout int lat);
      while (!bus4.done && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      if (!bus4.done) begin
         errors++;
         $display("[TB] FAIL %s: done never seen, got 0, expected 1", name);
      end
   endtask

   task automatic countDones(input int cycles, output int n);
      n = 0;
      repeat (cycles) begin
         @(negedge clk);
         if (bus4.done) n++;
      end
   endtask

   initial begin
      int lat;
      int gap;
      int n;

      bus4.start = 1'b0; bus4.a = '0; bus4.b = '0;
      bus8.start = 1'b0; bus8.a = '0; bus8.b = '0;
      #1 rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      $display("[TB] reset released");
      checkOutput("reset_ready",   64'(bus4.ready),   64'd1);
      checkOutput("reset_done",    64'(bus4.done),    64'd0);
      checkOutput("reset_product", 64'(bus4.product), 64'd0);

      // 15 x 15 = 225, done exactly one cycle after W steps
      applyStimulus(4'd15, 4'd15);
      checkOutput("busy_ready", 64'(bus4.ready), 64'd0);
      lat = 0;
      waitDone("done_15x15", lat);
      checkOutput("lat_15x15",     64'(lat),          64'd4);
      checkOutput("prod_15x15",    64'(bus4.product), 64'd225);
      checkOutput("model_225",     64'(m_product),    64'd225);
      @(negedge clk);
      checkOutput("done_one_cycle", 64'(bus4.done),   64'd0);
      checkOutput("ready_back",     64'(bus4.ready),  64'd1);
      repeat (3) @(negedge clk);
      checkOutput("prod_held",      64'(bus4.product), 64'd225);

      // back-to-back with start held high: 3x5 then 9x7
      @(negedge clk);
      bus4.a = 4'd3; bus4.b = 4'd5; bus4.start = 1'b1;
      @(negedge clk);
      bus4.a = 4'd9; bus4.b = 4'd7;
      lat = 0;
      waitDone("done_3x5", lat);
      checkOutput("lat_3x5",  64'(lat),          64'd4);
      checkOutput("prod_3x5", 64'(bus4.product), 64'd15);
      gap = 0;
      do begin
         @(negedge clk);
         gap++;
         if (gap == 2) bus4.start = 1'b0;
      end while (!bus4.done && gap < 40);
      checkOutput("b2b_interval", 64'(gap),          64'd6);
      checkOutput("prod_9x7",     64'(bus4.product), 64'd63);
      checkOutput("model_63",     64'(m_product),    64'd63);
      @(negedge clk);

      // start pulse during CALC is ignored
      applyStimulus(4'd10, 4'd12);
      @(negedge clk);
      bus4.a = 4'd1; bus4.b = 4'd1; bus4.start = 1'b1;
      @(negedge clk);
      bus4.start = 1'b0;
      lat = 2;
      waitDone("done_10x12", lat);
      checkOutput("lat_10x12",  64'(lat),          64'd4);
      checkOutput("prod_10x12", 64'(bus4.product), 64'd120);
      countDones(10, n);
      checkOutput("no_second_done", 64'(n),            64'd0);
      checkOutput("prod_120_held",  64'(bus4.product), 64'd120);

      // asynchronous reset two clocks into 6x6
      applyStimulus(4'd6, 4'd6);
      @(negedge clk);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checkOutput("abort_ready",   64'(bus4.ready),   64'd1);
      checkOutput("abort_done",    64'(bus4.done),    64'd0);
      checkOutput("abort_product", 64'(bus4.product), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      countDones(8, n);
      checkOutput("abort_no_done", 64'(n), 64'd0);
      applyStimulus(4'd2, 4'd8);
      lat = 0;
      waitDone("done_2x8", lat);
      checkOutput("lat_2x8",  64'(lat),          64'd4);
      checkOutput("prod_2x8", 64'(bus4.product), 64'd16);
      @(negedge clk);

      // zero operand: done rises on the accept edge with the shortcut,
      // otherwise after the full W steps
      applyStimulus(4'd0, 4'd13);
      lat = 0;
      waitDone("done_0x13", lat);
      checkOutput("lat_0x13",  64'(lat),          64'(ZERO_LAT));
      checkOutput("prod_0x13", 64'(bus4.product), 64'd0);
      @(negedge clk);
      checkOutput("ready_after_zero", 64'(bus4.ready), 64'd1);

      // WIDTH=8 maximum operands: 255*255 = 65025 after 8 steps
      @(negedge clk);
      bus8.a = 8'd255; bus8.b = 8'd255; bus8.start = 1'b1;
      @(negedge clk);
      bus8.start = 1'b0;
      checkOutput("w8_busy", 64'(bus8.ready), 64'd0);
      lat = 0;
      while (!bus8.done && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      checkOutput("w8_done",    64'(bus8.done),    64'd1);
      checkOutput("w8_latency", 64'(lat),          64'd8);
      checkOutput("w8_product", 64'(bus8.product), 64'd65025);
      @(negedge clk);
      checkOutput("w8_done_low", 64'(bus8.done),  64'd0);
      checkOutput("w8_ready",    64'(bus8.ready), 64'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL timeout: simulation still running, got 1, expected 0");
      $fatal(1, "[TB] timeout");
   end

endmodule
